// File: rtl/klp32_div_pkg.sv
// Shared types and constants for the KLP32 sequential divide unit.
package klp32_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // funct3[1:0] encodings of the RV32M divide group
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = 5;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/subtract32.sv
// 32-bit subtractor; borrow is set when a < b (unsigned).
module subtract32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] diff,
   output logic        borrow
);

   // Widen by one bit so the carry-out becomes the borrow flag
   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle RV32M restoring divider (DIV/DIVU/REM/REMU).
// Optional macro DIV32_SIGNED_EN enables signed DIV/REM; without it every op is unsigned.
module div32_seq
   import klp32_div_pkg::*;
#(
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

   state_t            state_q, state_d;
   logic [31:0]       dvd_q, dvs_q, part_q, orig_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              rem_q, div0_q;

   logic              accept, div0_in, ovf_in, special_in, take_fast;
   logic [31:0]       dvd_mag, dvs_mag, spec_res;
   logic [32:0]       shifted;
   logic [31:0]       sub_diff, part_nxt, quo_fix, rem_fix, fix_res;
   logic              sub_borrow, take;

`ifdef DIV32_SIGNED_EN
   logic              neg_quo_q, neg_rem_q, ovf_q;
   logic              sgn_in, dvd_neg_in, dvs_neg_in;

   // Sign-magnitude conversion of the incoming operands
   assign sgn_in     = ~op[0];
   assign dvd_neg_in = sgn_in & dividend[31];
   assign dvs_neg_in = sgn_in & divisor[31];
   assign dvd_mag    = dvd_neg_in ? (~dividend + 32'd1) : dividend;
   assign dvs_mag    = dvs_neg_in ? (~divisor + 32'd1) : divisor;
   assign ovf_in     = sgn_in & (dividend == INT_MIN) & (divisor == 32'hFFFF_FFFF);
`else
   logic              unused_op0;

   // op[0] only distinguishes signed from unsigned, which this build does not support
   assign unused_op0 = op[0];
   assign dvd_mag    = dividend;
   assign dvs_mag    = divisor;
   assign ovf_in     = 1'b0;
`endif

   assign div0_in    = (divisor == 32'd0);
   assign special_in = div0_in | ovf_in;
   assign take_fast  = FAST_SPECIAL && special_in;
   assign accept     = (state_q == IDLE) && start && !flush;

   // Forced result for a special case short-circuited at accept
   always_comb begin
      spec_res = 32'd0;
      if (div0_in) spec_res = op[1] ? dividend : DIV0_QUOT;
      else         spec_res = op[1] ? 32'd0 : INT_MIN;
   end

   // One restoring step: shift in the next dividend bit and try the subtract
   assign shifted  = {part_q, dvd_q[31]};
   assign take     = shifted[32] | ~sub_borrow;
   assign part_nxt = take ? sub_diff : shifted[31:0];

   subtract32 u_sub (
      .a      (shifted[31:0]),
      .b      (dvs_q),
      .diff   (sub_diff),
      .borrow (sub_borrow)
   );

   // Sign fixup and forced values applied once the iterations are finished
   always_comb begin
      quo_fix = dvd_q;
      rem_fix = part_q;
`ifdef DIV32_SIGNED_EN
      if (neg_quo_q) quo_fix = ~dvd_q + 32'd1;
      if (neg_rem_q) rem_fix = ~part_q + 32'd1;
      if (ovf_q) begin
         quo_fix = INT_MIN;
         rem_fix = 32'd0;
      end
`endif
      if (div0_q) begin
         quo_fix = DIV0_QUOT;
         rem_fix = orig_q;
      end
      fix_res = rem_q ? rem_fix : quo_fix;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = take_fast ? DONE : CALC;
         CALC: if (cnt_q == CNT_LAST) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // Registered handshake outputs decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_d != IDLE);
         done <= (state_d == DONE);
      end
   end

   // Operand capture, iteration datapath and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q     <= 32'd0;
         dvs_q     <= 32'd0;
         part_q    <= 32'd0;
         orig_q    <= 32'd0;
         cnt_q     <= '0;
         rem_q     <= 1'b0;
         div0_q    <= 1'b0;
         result    <= 32'd0;
`ifdef DIV32_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ovf_q     <= 1'b0;
`endif
      end else if (accept) begin
         dvd_q     <= dvd_mag;
         dvs_q     <= dvs_mag;
         part_q    <= 32'd0;
         orig_q    <= dividend;
         cnt_q     <= '0;
         rem_q     <= op[1];
         div0_q    <= div0_in;
`ifdef DIV32_SIGNED_EN
         neg_quo_q <= dvd_neg_in ^ dvs_neg_in;
         neg_rem_q <= dvd_neg_in;
         ovf_q     <= ovf_in;
`endif
         if (take_fast) result <= spec_res;
      end else if (state_q == CALC && !flush) begin
         part_q <= part_nxt;
         dvd_q  <= {dvd_q[30:0], take};
         cnt_q  <= cnt_q + CNT_W'(1);
      end else if (state_q == FIX && !flush) begin
         result <= fix_res;
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: one fast-special and one full-sequence instance.
`timescale 1ns/1ps
module tb_div32_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] dividend = 32'd0, divisor = 32'd0;
   logic        flush = 1'b0;
   logic        busy0, done0, busy1, done1;
   logic [31:0] result0, result1;

   int          total = 0;
   int          bad = 0;
   logic [31:0] last1 = 32'd0;

   always #5 clk = ~clk;

   div32_seq #(.FAST_SPECIAL(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .op(op), .dividend(dividend),
      .divisor(divisor), .flush(flush), .busy(busy0), .done(done0), .result(result0)
   );

   div32_seq #(.FAST_SPECIAL(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .op(op), .dividend(dividend),
      .divisor(divisor), .flush(flush), .busy(busy1), .done(done1), .result(result1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Issue one op to the chosen instance, then check busy, latency, result and the done pulse width
   task automatic run_op(input bit sel0, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] exp,
                         input string tag);
      int k;
      @(negedge clk);
      op = o; dividend = a; divisor = b;
      if (sel0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      dividend = $urandom; divisor = $urandom;
      k = 1;
      check({tag, "_busy"}, 32'(sel0 ? busy0 : busy1), 32'd1);
      while (!(sel0 ? done0 : done1) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_lat"}, 32'(k), 32'(lat));
      check({tag, "_res"}, sel0 ? result0 : result1, exp);
      if (!sel0) last1 = exp;
      @(negedge clk);
      check({tag, "_pulse"}, 32'(sel0 ? {busy0, done0} : {busy1, done1}), 32'd0);
   endtask

   initial begin
      logic saw_done;
      repeat (3) @(negedge clk);
      check("rst_busy",   32'(busy1), 32'd0);
      check("rst_done",   32'(done1), 32'd0);
      check("rst_result", result1, 32'd0);
      rst = 1'b0;

      run_op(1'b0, 2'b01, 32'd100, 32'd7, 34, 32'd14, "divu_100_7");
      run_op(1'b0, 2'b11, 32'd100, 32'd7, 34, 32'd2,  "remu_100_7");
      run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h10, 34, 32'h0FFF_FFFF, "divu_big");
      run_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h10, 34, 32'hF, "remu_big");

      run_op(1'b0, 2'b01, 32'd5, 32'd0, 1,  32'hFFFF_FFFF, "divu_z_fast");
      run_op(1'b0, 2'b11, 32'd5, 32'd0, 1,  32'd5,         "remu_z_fast");
      run_op(1'b1, 2'b01, 32'd5, 32'd0, 34, 32'hFFFF_FFFF, "divu_z_slow");
      run_op(1'b1, 2'b11, 32'd5, 32'd0, 34, 32'd5,         "remu_z_slow");

`ifdef DIV32_SIGNED_EN
      run_op(1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, "div_m7_2");
      run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, "rem_m7_2");
      run_op(1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000, "div_ovf_fast");
      run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'd0,         "rem_ovf_fast");
      run_op(1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, "div_ovf_slow");
`else
      run_op(1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2, 34, 32'h7FFF_FFFC, "div_m7_2_u");
      run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'd1,         "rem_m7_2_u");
      run_op(1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0,         "div_ovf_u");
      run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, "rem_ovf_u");
`endif

      // Flush partway through, with an ignored start while busy
      @(negedge clk);
      op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      saw_done = 1'b0;
      repeat (9) begin
         @(negedge clk);
         saw_done |= done1;
      end
      dividend = 32'd9; divisor = 32'd0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("ign_busy", 32'(busy1), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy",   32'(busy1), 32'd0);
      check("flush_result", result1, last1);
      repeat (40) begin
         @(negedge clk);
         saw_done |= done1;
      end
      check("flush_nodone", 32'(saw_done), 32'd0);
      check("flush_keep",   result1, last1);

      // Flush and start together: no accept
      op = 2'b01; dividend = 32'd8; divisor = 32'd2; start1 = 1'b1; flush = 1'b1;
      @(negedge clk);
      start1 = 1'b0; flush = 1'b0;
      check("flush_start", 32'(busy1), 32'd0);

      run_op(1'b0, 2'b01, 32'd1000, 32'd3, 34, 32'd333, "divu_after_flush");
      run_op(1'b0, 2'b11, 32'd1000, 32'd3, 34, 32'd1,   "remu_after_flush");

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      op = 2'b01; dividend = 32'd77; divisor = 32'd5; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy",   32'(busy1), 32'd0);
      check("mid_rst_done",   32'(done1), 32'd0);
      check("mid_rst_result", result1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF, "divu_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
Multi-cycle RV32M divide unit for KLP32 that sequences one shared subtract32 instance through 32 restoring-division iterations. It accepts DIV/DIVU/REM/REMU requests from the execute stage over a start/busy/done handshake and returns a 32-bit result. It sits beside the ALU and stalls the pipeline while busy.

Parameters:
FAST_SPECIAL, 1, 1 = divide-by-zero and signed-overflow complete in 1 cycle; 0 = they run the full iteration sequence.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend  input  32  rs1 value, sampled at accept
divisor  input  32  rs2 value, sampled at accept
flush  input  1  pipeline flush; aborts any operation
busy  output  1  high from the cycle after accept until done
done  output  1  1-cycle pulse; result valid
result  output  32  quotient (op[1]=0) or remainder (op[1]=1)

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, result=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 and flush=0 at edge N -> latch op, operands, sign flags; load |dividend|, |divisor| (signed ops only), partial remainder=0, counter=0.
  - Special case (divisor=0, or signed op with dividend=0x80000000 and divisor=0xFFFFFFFF) with FAST_SPECIAL=1: go to DONE.
  - Otherwise: go to CALC.
- CALC, one iteration per cycle:
  - shifted = {partial, next dividend MSB}, 33 bits.
  - subtract32 computes shifted[31:0] - divisor.
  - If shifted[32]=1 or shifted[31:0] >= divisor: partial = subtract32 result, quotient bit 1.
  - Else: partial = shifted[31:0], quotient bit 0.
  - Counter increments; after the 32nd iteration (edge N+32) go to FIX.
- FIX (one cycle):
  - Signed ops: negate quotient if operand signs differ; negate remainder if dividend was negative.
  - Forced values: divisor=0 -> quotient 0xFFFFFFFF, remainder = original dividend. Signed overflow -> quotient 0x80000000, remainder 0.
  - Select result by op[1]. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - Normal latency: done high in cycle N+34. Fast special case: cycle N+1.
- busy=1 in CALC, FIX and DONE; 0 in IDLE. start while busy=1 is ignored.
- result holds its value until the next FIX or fast-special DONE. It is not cleared on IDLE.
- flush=1 in any state -> IDLE at next edge, done never pulses, result unchanged. flush and start in the same cycle: flush wins, no accept.
- rst asserted mid-operation: immediate return to reset values.
- Operand inputs may change after accept without effect.

Optional Feature:
DIV32_SIGNED_EN
- Defined: DIV and REM use two's-complement sign handling and overflow rules as above.
- Undefined: op[0] is ignored and all ops are treated as unsigned (DIVU/REMU). The sign-magnitude negation and overflow detection logic is not built. Divide-by-zero handling is unchanged.

Decomposition:
- Package klp32_div_pkg: state encoding enum (IDLE, CALC, FIX, DONE); op codes OP_DIV, OP_DIVU, OP_REM, OP_REMU; constants ITER_COUNT=32, DIV0_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000.
- Sub-module: the existing subtract32, instantiated once as the shared datapath.
- The FSM, counter, shift registers and sign fixup live in div32_seq.

Test Plan:
- DIVU 100/7: start at edge N -> done in cycle N+34, result=14. Repeat as REMU -> result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1).
- DIVU 5/0 with FAST_SPECIAL=1 -> done at N+1, result 0xFFFFFFFF. REMU 5/0 -> 5. With FAST_SPECIAL=0 -> same values at N+34.
- DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000. REM -> 0. Without DIV32_SIGNED_EN the same operands give DIVU result 0.
- Flush at iteration 10 -> busy=0 next cycle, no done, prior result kept. Start pulsed during busy is ignored. Next start runs normally.
- rst asserted mid-CALC -> busy=0, done=0, result=0 immediately. Start 0xFFFFFFFF/1 DIVU after release -> 0xFFFFFFFF.
